// File: rtl/reg_file_param.sv
// Parameterised two-read/one-write register file with a power-up zeroing sweep.
// Define REGFILE_BYPASS_EN for write-first reads on a same-edge address match; read-first otherwise.
module reg_file_param #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          ADDR_W   = 4,
  parameter logic [DATA_W-1:0]    FILL_VAL = {DATA_W{1'b1}},
  parameter bit                   ZERO_REG = 1'b0,
  parameter int unsigned          DBG_IDX  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] DirA,
  input  logic [ADDR_W-1:0] DirB,
  input  logic [ADDR_W-1:0] Dir_WRA,
  input  logic [DATA_W-1:0] DI,
  input  logic              RE_A,
  input  logic              RE_B,
  input  logic              reg_WE,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB,
  output logic              ready,
  output logic [DATA_W-1:0] Reg_dbg
);

  localparam int unsigned        DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]  DBG_A = DBG_IDX[ADDR_W-1:0];

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                user_wr;

  logic [ADDR_W-1:0]   rd_addr [2];
  logic [DATA_W-1:0]   rd_data [2];

  assign rd_addr[0] = DirA;
  assign rd_addr[1] = DirB;
  assign user_wr    = ~reg_WE;

  // Per-port read source: hardwired zero entry first, then optional same-edge bypass.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = mem_q[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
        if (user_wr && (rd_addr[gi] == Dir_WRA)) begin
          rd_data[gi] = DI;
        end
`endif
        if (ZERO_REG && (rd_addr[gi] == '0)) begin
          rd_data[gi] = '0;
        end
      end
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_addr  = Dir_WRA;
    wr_data  = DI;
    data_a_d = FILL_VAL;
    data_b_d = FILL_VAL;
    case (state_q)
      INIT: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        wr_en = user_wr && !(ZERO_REG && (Dir_WRA == '0));
        if (!RE_A) data_a_d = rd_data[0];
        if (!RE_B) data_b_d = rd_data[1];
      end
      default: state_d = INIT;
    endcase
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  // Storage is never reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  generate
    if (ZERO_REG && (DBG_IDX == 0)) begin : g_dbg_zero
      assign Reg_dbg = '0;
    end else begin : g_dbg_mem
      assign Reg_dbg = mem_q[DBG_A];
    end
  endgenerate

  assign DataA = data_a_q;
  assign DataB = data_b_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised scoreboard bench for reg_file_param: one instance with ZERO_REG=0, one with ZERO_REG=1,
// both driven from the same stimulus and checked against an array-based reference model.
module tb_reg_file_param;
  localparam int DEPTH = 16;
  localparam logic [31:0] FILL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  dir_a = '0, dir_b = '0, dir_wra = '0;
  logic [31:0] di = '0;
  logic        re_a = 1'b1, re_b = 1'b1, reg_we = 1'b1;
  logic [31:0] data_a0, data_b0, dbg0, data_a1, data_b1, dbg1;
  logic        ready0, ready1;

  always #5 clk = ~clk;

  reg_file_param #(.ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .DirA(dir_a), .DirB(dir_b), .Dir_WRA(dir_wra), .DI(di),
    .RE_A(re_a), .RE_B(re_b), .reg_WE(reg_we),
    .DataA(data_a0), .DataB(data_b0), .ready(ready0), .Reg_dbg(dbg0)
  );

  reg_file_param #(.ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .DirA(dir_a), .DirB(dir_b), .Dir_WRA(dir_wra), .DI(di),
    .RE_A(re_a), .RE_B(re_b), .reg_WE(reg_we),
    .DataA(data_a1), .DataB(data_b1), .ready(ready1), .Reg_dbg(dbg1)
  );

  typedef struct {
    logic [31:0] a0, b0, a1, b1, d0, d1;
    bit          rdy, d0k, d1k;
  } exp_t;

  exp_t        sbq[$];
  exp_t        got;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m0 [DEPTH];
  logic [31:0] m1 [DEPTH];
  bit          k0 [DEPTH];
  bit          k1 [DEPTH];
  int          init_n = 0;
`ifdef REGFILE_BYPASS_EN
  bit          bypass = 1'b1;
`else
  bit          bypass = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_ref(input bit zr, input bit en_n, input int addr,
                                          input bit wr, input int waddr,
                                          input logic [31:0] wdata, input logic [31:0] stored);
    if (en_n) return FILL;
    if (zr && addr == 0) return 32'h0;
    if (wr && bypass && addr == waddr) return wdata;
    return stored;
  endfunction

  // Called at a negedge: drives one cycle, predicts the next posedge, waits for the following negedge.
  task automatic cycle(input int wa, input logic [31:0] d, input bit we_n,
                       input int ra, input bit rea_n, input int rb, input bit reb_n);
    exp_t e;
    dir_wra = wa[3:0]; di = d; reg_we = we_n;
    dir_a = ra[3:0]; re_a = rea_n; dir_b = rb[3:0]; re_b = reb_n;
    if (init_n < DEPTH) begin
      e.a0 = FILL; e.b0 = FILL; e.a1 = FILL; e.b1 = FILL;
      m0[init_n] = '0; m1[init_n] = '0; k0[init_n] = 1'b1; k1[init_n] = 1'b1;
      init_n++;
      e.rdy = (init_n == DEPTH);
    end else begin
      e.a0 = rd_ref(1'b0, rea_n, ra, !we_n, wa, d, m0[ra]);
      e.b0 = rd_ref(1'b0, reb_n, rb, !we_n, wa, d, m0[rb]);
      e.a1 = rd_ref(1'b1, rea_n, ra, !we_n, wa, d, m1[ra]);
      e.b1 = rd_ref(1'b1, reb_n, rb, !we_n, wa, d, m1[rb]);
      if (!we_n) begin
        m0[wa] = d; k0[wa] = 1'b1;
        if (wa != 0) begin
          m1[wa] = d; k1[wa] = 1'b1;
        end
      end
      e.rdy = 1'b1;
    end
    e.d0 = m0[1]; e.d0k = k0[1]; e.d1 = m1[1]; e.d1k = k1[1];
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic rand_cycle();
    int wa = $urandom_range(0, 15);
    int ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
    int rb = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 15);
    cycle(wa, $urandom, bit'($urandom_range(0, 1)), ra, bit'($urandom_range(0, 3) == 0),
          rb, bit'($urandom_range(0, 3) == 0));
  endtask

  task automatic check_reset_outputs();
    chk("rst_DataA0", data_a0, 32'h0);
    chk("rst_DataB0", data_b0, 32'h0);
    chk("rst_ready0", {31'h0, ready0}, 32'h0);
    chk("rst_DataA1", data_a1, 32'h0);
    chk("rst_DataB1", data_b1, 32'h0);
    chk("rst_ready1", {31'h0, ready1}, 32'h0);
  endtask

  // Called at a negedge with the scoreboard drained; returns at a negedge with rst released.
  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    init_n = 0;
  endtask

  // Monitor: every posedge has at most one predicted result waiting.
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      got = sbq.pop_front();
      chk("DataA0", data_a0, got.a0);
      chk("DataB0", data_b0, got.b0);
      chk("DataA1", data_a1, got.a1);
      chk("DataB1", data_b1, got.b1);
      chk("ready0", {31'h0, ready0}, {31'h0, got.rdy});
      chk("ready1", {31'h0, ready1}, {31'h0, got.rdy});
      if (got.d0k) chk("Reg_dbg0", dbg0, got.d0);
      if (got.d1k) chk("Reg_dbg1", dbg1, got.d1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    init_n = 0;

    // Power-up sweep with idle inputs, then directed scenarios.
    repeat (DEPTH) cycle(0, 32'h0, 1'b1, 0, 1'b1, 0, 1'b1);
    cycle(1, 32'h0000_04D2, 1'b0, 0, 1'b1, 0, 1'b1);
    cycle(0, 32'h0, 1'b1, 1, 1'b0, 1, 1'b0);
    cycle(0, 32'h0, 1'b1, 0, 1'b1, 0, 1'b1);
    cycle(2, 32'h0000_1991, 1'b0, 2, 1'b0, 2, 1'b1);
    cycle(3, 32'h0000_2313, 1'b0, 0, 1'b1, 0, 1'b1);
    cycle(0, 32'h0, 1'b1, 3, 1'b1, 3, 1'b0);
    cycle(0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1, 0, 1'b1);
    cycle(0, 32'h0, 1'b1, 0, 1'b0, 0, 1'b0);
    cycle(0, 32'h1234_5678, 1'b0, 0, 1'b0, 0, 1'b0);
    cycle(15, 32'hA5A5_0F0F, 1'b0, 15, 1'b0, 14, 1'b0);

    repeat (300) rand_cycle();

    // Reset in RUN: full sweep again, then every entry reads zero.
    reset_pulse();
    repeat (DEPTH) rand_cycle();
    for (int i = 0; i < DEPTH; i++) cycle(0, 32'h0, 1'b1, i, 1'b0, DEPTH - 1 - i, 1'b0);
    repeat (50) rand_cycle();

    // Reset mid-sweep at count 7.
    reset_pulse();
    repeat (7) rand_cycle();
    reset_pulse();
    repeat (DEPTH) rand_cycle();
    for (int i = 0; i < DEPTH; i++) cycle(0, 32'h0, 1'b1, i, 1'b0, i, 1'b0);
    repeat (100) rand_cycle();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter FILL_VAL, default all-ones of DATA_W: value driven on a disabled or not-ready read.
REQ-004 SHALL have parameter ZERO_REG, default 0: when 1, entry 0 reads as 0 and ignores writes.
REQ-005 SHALL have parameter DBG_IDX, default 1: entry mirrored on Reg_dbg.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port DirA  input  ADDR_W  read address, port A.
REQ-009 SHALL have port DirB  input  ADDR_W  read address, port B.
REQ-010 SHALL have port Dir_WRA  input  ADDR_W  write address.
REQ-011 SHALL have port DI  input  DATA_W  write data.
REQ-012 SHALL have port RE_A  input  1  read enable A, active-low.
REQ-013 SHALL have port RE_B  input  1  read enable B, active-low.
REQ-014 SHALL have port reg_WE  input  1  write enable, active-low.
REQ-015 SHALL have port DataA  output  DATA_W  registered read data A.
REQ-016 SHALL have port DataB  output  DATA_W  registered read data B.
REQ-017 SHALL have port ready  output  1  high when init sweep done and file accepts accesses.
REQ-018 SHALL have port Reg_dbg  output  DATA_W  combinational mirror of entry DBG_IDX.

Function
REQ-019 SHALL implement FSM states INIT and RUN; reset enters INIT with sweep counter 0.
REQ-020 In INIT, SHALL write 0 to entry[counter] each cycle, increment counter, go to RUN after entry DEPTH-1 written (DEPTH cycles), ready = (state==RUN), registered.
REQ-021 In INIT, SHALL ignore reg_WE and drive FILL_VAL on DataA/DataB at each edge.
REQ-022 In RUN, on rising edge with reg_WE=0, SHALL write DI to entry[Dir_WRA] (except entry 0 when ZERO_REG=1).
REQ-023 In RUN, on rising edge, DataA SHALL load entry[DirA] if RE_A=0 else FILL_VAL; DataB likewise with DirB/RE_B; read latency one cycle.
REQ-024 Both read ports SHALL be independent; equal DirA and DirB SHALL return identical data.
REQ-025 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of prior writes.
REQ-026 Same-cycle read and write to one address SHALL follow REQ-033/REQ-034.
REQ-027 Addresses SHALL be full-range; no out-of-range case exists (DEPTH = 2**ADDR_W).
REQ-028 Reg_dbg SHALL reflect a write to DBG_IDX in the cycle after the write edge.

Reset
REQ-029 Asserting rst SHALL immediately force DataA=0, DataB=0, ready=0, state=INIT, counter=0.
REQ-030 Memory contents SHALL NOT be reset directly; they are zeroed by the INIT sweep.
REQ-031 rst asserted mid-sweep or mid-RUN SHALL restart the full DEPTH-cycle sweep after release.
REQ-032 First rising edge after rst deasserts SHALL perform sweep write of entry 0.

Configuration
REQ-033 With macro REGFILE_BYPASS_EN defined, a same-edge read and write (RUN, reg_WE=0, enabled read, equal address) SHALL return DI (write-first), except entry 0 when ZERO_REG=1 returns 0.
REQ-034 Without REGFILE_BYPASS_EN, that read SHALL return the entry's old value (read-first).

Verification
REQ-035 Release rst; count cycles -> ready rises exactly DEPTH=16 cycles later; DataA=FILL_VAL (0xFFFFFFFF) during sweep.
REQ-036 RUN: write 0x000004D2 to addr 1, next cycle read A addr 1, B addr 1 -> both 0x000004D2 one cycle later; Reg_dbg=0x000004D2.
REQ-037 Same edge write 0x00001991 to addr 2 and read A addr 2 (prior 0) -> 0x00001991 with REGFILE_BYPASS_EN, 0x00000000 without.
REQ-038 RE_A=1, RE_B=0 addr 3 holding 0x00002313 -> DataA=0xFFFFFFFF, DataB=0x00002313.
REQ-039 ZERO_REG=1: write 0xDEADBEEF to addr 0, read addr 0 -> 0x00000000.
REQ-040 Assert rst for 1 cycle at sweep count 7 and in RUN after writes -> outputs 0 at once, ready low, full 16-cycle sweep repeats, all entries read 0.
